dsm_dac_mod2: RTL and testbench

Parametrised delta-sigma DAC modulator with runtime-selectable first or second order, a built-in oversampling sample-rate handshake, saturating integrators and sticky status flags. It sits between the sample source and the 1-bit output pin, which drives an external RC reconstruction filter. It supersedes the fixed first-order modulator and moves the OSR pacing inside the block, so the source only answers a ready/valid handshake.

---
 rtl/dsm_dac_mod2.sv | 172 +++++++++++++++++
 tb/tb_dsm_dac_mod2.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_dac_mod2.sv
// dsm_dac_mod2: 1st/2nd-order delta-sigma DAC modulator with OSR pacing.
// Define DSM_DITHER_EN to add LFSR dither to the quantiser.
module dsm_dac_mod2 #(
  parameter int DATA_WIDTH = 16,
  parameter int OSR        = 64,
  parameter int GUARD      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_order2,
  input  logic                  i_clr_flags,
  output logic                  o_dac_bitstream,
  output logic                  o_underrun,
  output logic                  o_ovf
);

  localparam int ACC_W = DATA_WIDTH + GUARD;
  localparam int SUM_W = ACC_W + 2;
  localparam int CNT_W = $clog2(OSR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

  localparam logic signed [SUM_W-1:0] M_S =
    {{(SUM_W-DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {3'b111, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0]      i1_q, i1_d, i2_q, i2_d;
  logic signed [DATA_WIDTH-1:0] x_q, x_d, pend_q, pend_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic pend_full_q, pend_full_d;
  logic mode_q, mode_d;
  logic seen_q, seen_d;
  logic bit_q, bit_d;
  logic und_q, und_d;
  logic ovf_q, ovf_d;

  logic signed [SUM_W-1:0] i1_e, i2_e, x_e, q_e, dith, qd, fb, s1, s2;
  logic y, bnd, take, mode_chg, accept, clip1, clip2, und_set, ovf_set;

`ifdef DSM_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
`endif

  function automatic logic signed [ACC_W-1:0] clamp(
    input logic signed [SUM_W-1:0] s
  );
    if (s > SAT_MAX)      clamp = SAT_MAX[ACC_W-1:0];
    else if (s < SAT_MIN) clamp = SAT_MIN[ACC_W-1:0];
    else                  clamp = s[ACC_W-1:0];
  endfunction

  // Quantiser, integrator update, sample transfer and flag logic.
  always_comb begin
    i1_e = {{2{i1_q[ACC_W-1]}}, i1_q};
    i2_e = {{2{i2_q[ACC_W-1]}}, i2_q};
    x_e  = {{(SUM_W-DATA_WIDTH){x_q[DATA_WIDTH-1]}}, x_q};
`ifdef DSM_DITHER_EN
    dith = {{(SUM_W-2){lfsr_q[1]}}, lfsr_q[1:0]};
`else
    dith = '0;
`endif
    q_e  = mode_q ? i2_e : i1_e;
    qd   = q_e + dith;
    y    = ~qd[SUM_W-1];
    fb   = y ? M_S : -M_S;
    s1   = i1_e + x_e - fb;
    s2   = i2_e + i1_e - fb;
    clip1 = (s1 > SAT_MAX) || (s1 < SAT_MIN);
    clip2 = (s2 > SAT_MAX) || (s2 < SAT_MIN);

    bnd      = i_en && (cnt_q == CNT_LAST);
    take     = bnd && pend_full_q;
    mode_chg = take && (i_order2 != mode_q);
    accept   = i_valid && !pend_full_q;
    und_set  = bnd && !pend_full_q && seen_q;
    ovf_set  = 1'b0;

    i1_d        = i1_q;
    i2_d        = i2_q;
    x_d         = x_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    seen_d      = seen_q;
    bit_d       = bit_q;
`ifdef DSM_DITHER_EN
    lfsr_d = lfsr_q;
`endif

    if (accept) begin
      pend_d      = i_data;
      pend_full_d = 1'b1;
      seen_d      = 1'b1;
    end

    if (i_en) begin
      bit_d = y;
      cnt_d = bnd ? '0 : cnt_q + 1'b1;
`ifdef DSM_DITHER_EN
      lfsr_d = {lfsr_q[14:0],
                lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
      if (mode_chg) begin
        i1_d = '0;
        i2_d = '0;
      end else begin
        i1_d    = clamp(s1);
        i2_d    = mode_q ? clamp(s2) : '0;
        ovf_set = clip1 || (mode_q && clip2);
      end
    end

    if (take) begin
      x_d         = pend_q;
      pend_full_d = 1'b0;
      mode_d      = i_order2;
    end

    und_d = i_clr_flags ? 1'b0 : (und_q || und_set);
    ovf_d = i_clr_flags ? 1'b0 : (ovf_q || ovf_set);
  end

  // State registers; reset discards all samples and modulator state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      i1_q        <= '0;
      i2_q        <= '0;
      x_q         <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      seen_q      <= 1'b0;
      bit_q       <= 1'b0;
      und_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      x_q         <= x_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      seen_q      <= seen_d;
      bit_q       <= bit_d;
      und_q       <= und_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef DSM_DITHER_EN
  // Dither generator, advances once per tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end
`endif

  assign o_ready         = !pend_full_q;
  assign o_dac_bitstream = bit_q;
  assign o_underrun      = und_q;
  assign o_ovf           = ovf_q;

endmodule

// File: tb/tb_dsm_dac_mod2.sv
// tb_dsm_dac_mod2: directed checks of the delta-sigma modulator.
// Second instance uses GUARD=1, OSR=4 for saturation.
module tb_dsm_dac_mod2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en, valid, order2, clr;
  logic [15:0] data;
  logic rdy, obit, und, ovf;

  logic en2, valid2, order2b, clr2;
  logic [15:0] data2;
  logic rdy2, obit2, und2, ovf2;

  int n_cmp = 0;
  int n_bad = 0;
  int ticks = 0;

  dsm_dac_mod2 u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid),
    .o_ready(rdy), .i_data(data), .i_order2(order2),
    .i_clr_flags(clr), .o_dac_bitstream(obit),
    .o_underrun(und), .o_ovf(ovf)
  );

  dsm_dac_mod2 #(.DATA_WIDTH(16), .OSR(4), .GUARD(1)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en2), .i_valid(valid2),
    .o_ready(rdy2), .i_data(data2), .i_order2(order2b),
    .i_clr_flags(clr2), .o_dac_bitstream(obit2),
    .o_underrun(und2), .o_ovf(ovf2)
  );

  task automatic chk(input string tag, input longint obs,
                     input longint exp, input longint tol = 0);
    n_cmp++;
    if (obs > exp + tol || obs < exp - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)",
               tag, obs, exp, tol);
    end
  endtask

  task automatic run(input int n, output int ones,
                     output logic [15:0] hist);
    ones = 0;
    hist = '0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      ones += int'(obit);
      hist = {hist[14:0], obit};
      if (en) ticks++;
    end
  endtask

  task automatic sync_bnd();
    int o;
    logic [15:0] h;
    run(64 - (ticks % 64), o, h);
  endtask

  task automatic load(input logic [15:0] d);
    int o;
    logic [15:0] h;
    valid = 1'b1;
    data  = d;
    run(1, o, h);
    valid = 1'b0;
  endtask

  task automatic clr_flags();
    logic e;
    e   = en;
    en  = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    en  = e;
  endtask

  initial begin
    int ones, o2, acc, nrdy, chg;
    logic [15:0] h;
    logic b0;

    rst_n = 1'b0;
    en = 0; valid = 0; order2 = 0; clr = 0; data = '0;
    en2 = 0; valid2 = 0; order2b = 0; clr2 = 0; data2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_bit", obit, 0);
    chk("rst_und", und, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rdy", rdy, 1);
    chk("rst_rdy2", rdy2, 1);
    chk("rst_bit2", obit2, 0);
    chk("rst_und2", und2, 0);

    rst_n = 1'b1;
    @(negedge clk);

    // accept sample 0 with ticks disabled
    valid = 1'b1;
    data  = 16'd0;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    chk("rdy_low_acc", rdy, 0);

    // first-order idle pattern
    en = 1'b1;
    run(64, ones, h);
    chk("rdy_back", rdy, 1);
    chk("no_und_first", und, 0);
    run(8, ones, h);
    chk("fo_idle_pat", h[7:0], 8'hAA);
    chk("fo_idle_ovf", ovf, 0);

    // first-order density
    load(16'd16384);
    chk("rdy_low_load", rdy, 0);
    sync_bnd();
    run(1024, ones, h);
    chk("fo_dens_pos", ones, 768, 1);
    load(16'hC000);
    sync_bnd();
    run(1024, ones, h);
    chk("fo_dens_neg", ones, 256, 1);
    chk("fo_ovf", ovf, 0);
    chk("und_idle_set", und, 1);

    // switch to second order: integrators cleared at boundary
    order2 = 1'b1;
    load(16'd0);
    sync_bnd();
    run(8, ones, h);
    chk("so_clear_pat", h[7:0], 8'b1001_1001);
    run(1016, o2, h);
    chk("so_dens_zero", ones + o2, 512, 2);
    load(16'd8192);
    sync_bnd();
    run(1024, ones, h);
    chk("so_dens_pos", ones, 640, 2);

    clr_flags();
    chk("und_clr", und, 0);

    // continuous valid: one acceptance per period
    valid = 1'b1;
    data  = 16'd4096;
    acc   = 0;
    nrdy  = 0;
    repeat (192) begin
      acc  += int'(rdy & valid);
      nrdy += int'(!rdy);
      run(1, ones, h);
    end
    valid = 1'b0;
    chk("hs_accepts", acc, 3);
    chk("hs_rdy_low", nrdy, 189);
    chk("hs_no_und", und, 0);

    // withheld sample: underrun, x retained
    sync_bnd();
    chk("und_set", und, 1);
    run(1024, ones, h);
    chk("x_retained", ones, 576, 2);
    clr_flags();
    chk("und_clr2", und, 0);

    // enable low freezes bitstream and counter
    run(30, ones, h);
    b0  = obit;
    en  = 1'b0;
    chg = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      chg += int'(obit != b0);
    end
    en = 1'b1;
    chk("en_freeze_bit", chg, 0);
    run(33, ones, h);
    chk("cnt_frozen", und, 0);
    run(1, ones, h);
    chk("cnt_bnd", und, 1);

    // asynchronous reset mid-period
    load(16'd100);
    chk("pre_rst_rdy", rdy, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bit", obit, 0);
    chk("arst_rdy", rdy, 1);
    chk("arst_und", und, 0);
    chk("arst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks = 0;
    run(8, ones, h);
    chk("rst_idle_pat", h[7:0], 8'hAA);
    run(56, ones, h);
    chk("rst_no_und", und, 0);
    chk("rst_rdy_after", rdy, 1);

    // saturation on narrow-guard instance
    en2     = 1'b1;
    valid2  = 1'b1;
    data2   = 16'd32767;
    order2b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid2 = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("sat_ovf", ovf2, 1);
    clr2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ovf_clr_prio", ovf2, 0);
    clr2 = 1'b0;
    chk("main_ovf_zero", ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
